// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT result drain: geometry constants, the drain
// FSM state encoding, error bit positions and the index bit-reversal helper.
package ntt_pkg;

  localparam int LOG_CORE_COUNT = 4;
  localparam int LOG_WORDS      = 11;
  localparam int DATA_W         = 60;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } drain_state_e;

  // Sticky error flag positions inside err[1:0]
  localparam int ERR_OVERRUN = 0;
  localparam int ERR_SHORT   = 1;

  // Reverse the bit order of a LOG_WORDS-bit word index
  function automatic logic [LOG_WORDS-1:0] bitrev(input logic [LOG_WORDS-1:0] v);
    logic [LOG_WORDS-1:0] r;
    r = {LOG_WORDS{1'b0}};
    for (int i = 0; i < LOG_WORDS; i++) begin
      r[i] = v[LOG_WORDS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_drain_bank.sv
// One storage bank of the result drain: simple dual-port RAM with one write
// port and one synchronous read port (read data valid the cycle after re).
module ntt_drain_bank #(
  parameter int DATA_W    = 60,
  parameter int LOG_DEPTH = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [LOG_DEPTH-1:0] waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 re,
  input  logic [LOG_DEPTH-1:0] raddr,
  output logic [DATA_W-1:0]    rdata
);
  import ntt_pkg::*;

  logic [DATA_W-1:0] mem_q [2**LOG_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Write port: storage has no reset, contents are undefined after reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Synchronous read port: data register only updates on a read request
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ntt_result_drain.sv
// NTT result drain: captures the processor's parallel final-stage burst into
// 2*2^LOG_CORE_COUNT banks, then replays all 2^LOG_WORDS words as a single
// valid/ready stream with a word index.
// Build option: define NTT_DRAIN_BITREV_EN to read beat k from stored index
// bitrev(k) while still reporting m_index = k.
module ntt_result_drain #(
  parameter int LOG_CORE_COUNT = ntt_pkg::LOG_CORE_COUNT,
  parameter int DATA_W         = ntt_pkg::DATA_W,
  parameter int LOG_WORDS      = ntt_pkg::LOG_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 output_active,
  input  logic [DATA_W-1:0]    out [2**LOG_CORE_COUNT][2],
  input  logic [8:0]           address_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic [LOG_WORDS-1:0] m_index,
  output logic                 m_last,
  output logic                 busy,
  output logic [1:0]           err
);
  import ntt_pkg::*;

  localparam int NCORES    = 2**LOG_CORE_COUNT;
  localparam int NBANKS    = 2 * NCORES;
  localparam int LOG_BANKS = LOG_CORE_COUNT + 1;
  localparam int LOG_DEPTH = LOG_WORDS - 1 - LOG_CORE_COUNT;

  localparam logic [LOG_DEPTH:0]   BEAT_FULL = 1 << LOG_DEPTH;
  localparam logic [LOG_DEPTH:0]   BEAT_ONE  = 1;
  localparam logic [LOG_WORDS:0]   PTR_ONE   = 1;
  localparam logic [LOG_WORDS-1:0] IDX_LAST  = {LOG_WORDS{1'b1}};

  drain_state_e state_q, state_d;
  logic [LOG_DEPTH:0]   beat_q, beat_d;
  logic [1:0]           err_q, err_d;
  logic                 busy_q, busy_d;
  logic [LOG_WORDS:0]   rd_ptr_q, rd_ptr_d;

  // Read stage (one word in flight out of the banks)
  logic                 rd_vld_q, rd_vld_d;
  logic [LOG_BANKS-1:0] rd_bank_q, rd_bank_d;
  logic [LOG_WORDS-1:0] rd_idx_q, rd_idx_d;
  logic                 rd_last_q, rd_last_d;

  // Output register and skid entry
  logic                 out_vld_q, out_vld_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic [LOG_WORDS-1:0] out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 skid_vld_q, skid_vld_d;
  logic [DATA_W-1:0]    skid_data_q, skid_data_d;
  logic [LOG_WORDS-1:0] skid_idx_q, skid_idx_d;
  logic                 skid_last_q, skid_last_d;

  logic                 wr_en_s;
  logic [LOG_DEPTH-1:0] wr_addr_s;
  logic                 drain_on_s;
  logic                 accept_s;
  logic [1:0]           occ_s;
  logic                 rd_issue_s;
  logic [LOG_WORDS-1:0] rd_sidx_s;
  logic [DATA_W-1:0]    rd_word_s;
  logic [DATA_W-1:0]    bank_rdata_s [NBANKS];
  logic                 unused_addr_s;

  assign unused_addr_s = ^address_out[8:LOG_DEPTH];

  // Write enable, read issue and stored-index selection
  always_comb begin
    wr_en_s    = output_active && (state_q != ST_DRAIN);
    wr_addr_s  = address_out[LOG_DEPTH-1:0];
    // Reads may start in the cycle the burst frame drops, hiding the RAM latency
    drain_on_s = (state_q == ST_DRAIN) || ((state_q == ST_CAPTURE) && !output_active);
    accept_s   = out_vld_q && m_ready;
    occ_s      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_vld_q};
    // At most two words in output+skid+flight once this cycle's accept retires
    rd_issue_s = drain_on_s && !rd_ptr_q[LOG_WORDS] && ((occ_s - {1'b0, accept_s}) < 2'd2);
`ifdef NTT_DRAIN_BITREV_EN
    rd_sidx_s  = bitrev(rd_ptr_q[LOG_WORDS-1:0]);
`else
    rd_sidx_s  = rd_ptr_q[LOG_WORDS-1:0];
`endif
    rd_word_s  = bank_rdata_s[rd_bank_q];
  end

  // Bank array: bank {lane, core} holds index {lane, core, addr}
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    ntt_drain_bank #(
      .DATA_W   (DATA_W),
      .LOG_DEPTH(LOG_DEPTH)
    ) u_bank (
      .clk  (clk),
      .we   (wr_en_s),
      .waddr(wr_addr_s),
      .wdata(out[b % NCORES][b / NCORES]),
      .re   (rd_issue_s),
      .raddr(rd_sidx_s[LOG_DEPTH-1:0]),
      .rdata(bank_rdata_s[b])
    );
  end

  // FSM next state, capture beat counter and sticky errors
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (output_active) begin
          state_d = ST_CAPTURE;
          beat_d  = BEAT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (output_active) begin
          if (beat_q != BEAT_FULL) begin
            beat_d = beat_q + BEAT_ONE;
          end else begin
            beat_d = beat_q;
          end
        end else begin
          state_d = ST_DRAIN;
          if (beat_q != BEAT_FULL) begin
            err_d[ERR_SHORT] = 1'b1;
          end else begin
            err_d[ERR_SHORT] = err_q[ERR_SHORT];
          end
        end
      end
      ST_DRAIN: begin
        if (output_active) begin
          err_d[ERR_OVERRUN] = 1'b1;
        end else begin
          err_d[ERR_OVERRUN] = err_q[ERR_OVERRUN];
        end
        if (accept_s && out_last_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Read pointer and read-stage tracking
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_ptr_d = {(LOG_WORDS+1){1'b0}};
    end else if (rd_issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    rd_vld_d  = rd_issue_s;
    rd_bank_d = rd_sidx_s[LOG_WORDS-1:LOG_DEPTH];
    rd_idx_d  = rd_ptr_q[LOG_WORDS-1:0];
    rd_last_d = (rd_ptr_q[LOG_WORDS-1:0] == IDX_LAST);
  end

  // Output register plus skid entry; the output only moves when empty or accepted
  always_comb begin
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_idx_d  = skid_idx_q;
    skid_last_d = skid_last_q;
    if (!out_vld_q || accept_s) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = skid_data_q;
        out_idx_d  = skid_idx_q;
        out_last_d = skid_last_q;
        skid_vld_d = rd_vld_q;
        if (rd_vld_q) begin
          skid_data_d = rd_word_s;
          skid_idx_d  = rd_idx_q;
          skid_last_d = rd_last_q;
        end else begin
          skid_last_d = 1'b0;
        end
      end else begin
        out_vld_d = rd_vld_q;
        if (rd_vld_q) begin
          out_data_d = rd_word_s;
          out_idx_d  = rd_idx_q;
          out_last_d = rd_last_q;
        end else begin
          out_last_d = 1'b0;
        end
      end
    end else begin
      if (rd_vld_q) begin
        skid_vld_d  = 1'b1;
        skid_data_d = rd_word_s;
        skid_idx_d  = rd_idx_q;
        skid_last_d = rd_last_q;
      end else begin
        skid_vld_d = skid_vld_q;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      beat_q   <= {(LOG_DEPTH+1){1'b0}};
      err_q    <= 2'b00;
      busy_q   <= 1'b0;
      rd_ptr_q <= {(LOG_WORDS+1){1'b0}};
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Read-stage and output/skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q    <= 1'b0;
      rd_bank_q   <= {LOG_BANKS{1'b0}};
      rd_idx_q    <= {LOG_WORDS{1'b0}};
      rd_last_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_idx_q   <= {LOG_WORDS{1'b0}};
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= {DATA_W{1'b0}};
      skid_idx_q  <= {LOG_WORDS{1'b0}};
      skid_last_q <= 1'b0;
    end else begin
      rd_vld_q    <= rd_vld_d;
      rd_bank_q   <= rd_bank_d;
      rd_idx_q    <= rd_idx_d;
      rd_last_q   <= rd_last_d;
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_idx_q  <= skid_idx_d;
      skid_last_q <= skid_last_d;
    end
  end

  assign m_valid = out_vld_q;
  assign m_data  = out_data_q;
  assign m_index = out_idx_q;
  assign m_last  = out_last_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: tb/tb_ntt_result_drain.sv
// Directed bench for ntt_result_drain: full/short/overrun bursts, random
// backpressure, reset mid-drain, back-to-back bursts. Expected words come from
// a bench-side image of what was written into storage.
module tb_ntt_result_drain;

  localparam int NC = 16;
  localparam int DW = 60;
  localparam int NW = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          output_active;
  logic [DW-1:0] out_s [NC][2];
  logic [8:0]    address_out;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [10:0]   m_index;
  logic          m_last;
  logic          busy;
  logic [1:0]    err;

  logic [DW-1:0] model [NW];
  int            n_chk = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  ntt_result_drain dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .output_active(output_active),
    .out          (out_s),
    .address_out  (address_out),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_index      (m_index),
    .m_last       (m_last),
    .busy         (busy),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [11:0] tag, input int idx);
    return {tag, 37'd0, 11'(idx)};
  endfunction

  function automatic int brev11(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) r = r | (1 << (10 - i));
    end
    return r;
  endfunction

  // n capture beats, addresses in a scrambled order, upper address bits junk
  task automatic burst(input int n, input logic [11:0] tag);
    int a;
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      if (b == 1) chk("cap_busy", busy, 1'b1);
      a = (b * 37) % 64;
      output_active = 1'b1;
      address_out = 9'(a) | 9'h140;
      for (int c = 0; c < NC; c++) begin
        for (int l = 0; l < 2; l++) begin
          out_s[c][l] = mk(tag, l * 1024 + c * 64 + a);
          model[l * 1024 + c * 64 + a] = mk(tag, l * 1024 + c * 64 + a);
        end
      end
    end
    @(negedge clk);
    output_active = 1'b0;
  endtask

  // Consume a drain; optional overrun injection and reset at a given beat
  task automatic drain(input bit bp, input int ovr_at, input int rst_at,
                       output int first_v, output int last_cyc);
    int k, cyc, ovr_left, si;
    bit held, ovr_done, stop;
    logic [72:0] held_v;
    k = 0; cyc = 0; ovr_left = 0; held = 1'b0; ovr_done = 1'b0; stop = 1'b0;
    first_v = -1; last_cyc = -1;
    while (!stop && k < NW && cyc < 20000) begin
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at) begin
        rst_n = 1'b0;
        output_active = 1'b0;
        #1;
        chk("rst_mid_drain", {m_valid, m_last, busy, err, m_index, m_data}, 76'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stop = 1'b1;
      end else begin
        if (m_valid && first_v < 0) first_v = cyc;
        if (held) chk("stall_hold", {m_valid, m_last, m_index, m_data}, held_v);
        if (ovr_at >= 0 && k >= ovr_at && !ovr_done) begin
          ovr_left = 10;
          ovr_done = 1'b1;
        end
        if (ovr_left > 0) begin
          output_active = 1'b1;
          address_out = 9'(ovr_left);
          for (int c = 0; c < NC; c++) begin
            for (int l = 0; l < 2; l++) out_s[c][l] = mk(12'hEEE, ovr_left);
          end
          ovr_left--;
        end else begin
          output_active = 1'b0;
        end
        m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        if (m_valid && m_ready) begin
`ifdef NTT_DRAIN_BITREV_EN
          si = brev11(k);
`else
          si = k;
`endif
          chk("beat", {m_last, m_index, m_data}, {(k == NW - 1), 11'(k), model[si]});
          last_cyc = cyc;
          k++;
          held = 1'b0;
        end else begin
          held = m_valid;
          held_v = {m_valid, m_last, m_index, m_data};
        end
        cyc++;
      end
    end
    if (rst_at < 0) chk("drain_count", k, NW);
  endtask

  initial begin
    int fv, lc;
    rst_n = 1'b0;
    output_active = 1'b0;
    m_ready = 1'b0;
    address_out = 9'd0;
    for (int c = 0; c < NC; c++) begin
      for (int l = 0; l < 2; l++) out_s[c][l] = {DW{1'b0}};
    end
    repeat (3) @(negedge clk);
    chk("reset_state", {m_valid, m_last, busy, err, m_index, m_data}, 76'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, m_valid, err}, 4'd0);

    // Full burst, natural data = index, full throughput
    m_ready = 1'b1;
    burst(64, 12'h000);
    drain(1'b0, -1, -1, fv, lc);
    chk("t1_first_valid_cycle", fv, 1);
    chk("t1_last_accept_cycle", lc, 2048);
    chk("t1_err", err, 2'b00);
    @(negedge clk);
    chk("t1_idle", {busy, m_valid, m_last}, 3'd0);

    // Full burst under random backpressure
    burst(64, 12'h222);
    drain(1'b1, -1, -1, fv, lc);
    chk("t2_err", err, 2'b00);

    // Short burst starting right after the last accept; stale words remain
    burst(40, 12'h333);
    @(negedge clk);
    chk("t3_err_short", err, 2'b10);
    chk("t3_busy", busy, 1'b1);
    drain(1'b0, -1, -1, fv, lc);
    chk("t3_err_after", err, 2'b10);

    // Overrun during drain must not disturb stored data
    burst(64, 12'h444);
    drain(1'b0, 100, -1, fv, lc);
    chk("t4_err_overrun", err, 2'b11);

    // Reset mid-drain, then a fresh burst drains from index 0
    burst(64, 12'h555);
    drain(1'b1, -1, 500, fv, lc);
    chk("t5_after_reset", {busy, m_valid, err}, 4'd0);
    burst(64, 12'h666);
    drain(1'b0, -1, -1, fv, lc);
    chk("t5_first_valid_cycle", fv, 1);
    chk("t5_err", err, 2'b00);
    @(negedge clk);
    chk("t5_idle", {busy, m_valid}, 2'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
